// File: rtl/rx_flip_decoder_pkg.sv
// Shared definitions for the flip-pattern receive decoder: weight-2 code table,
// the one illegal weight-2 flip, the control state enum and output buffer sizing.
package rx_flip_decoder_pkg;

    localparam int unsigned FifoDepth = 2;
    localparam int unsigned W2Entries = 20;
    localparam logic [6:0]  IllegalFlip = 7'h60;
    localparam logic [5:0]  W2Base = 6'h2C;

    // Weight-2 flips in code order; entry i decodes to W2Base + i.
    localparam logic [6:0] W2Table [W2Entries] = '{
        7'h03, 7'h05, 7'h09, 7'h11, 7'h21, 7'h41,
        7'h06, 7'h0A, 7'h12, 7'h22, 7'h42,
        7'h0C, 7'h14, 7'h24, 7'h44,
        7'h18, 7'h28, 7'h48,
        7'h30,
        7'h50
    };

    typedef enum logic [0:0] {
        StPrime,
        StRun
    } state_e;

    typedef struct packed {
        logic       err;
        logic [5:0] data;
    } entry_t;

    function automatic logic [2:0] flip_weight(input logic [6:0] flip);
        logic [2:0] w;
        w = '0;
        for (int i = 0; i < 7; i++) begin
            w = w + {2'b00, flip[i]};
        end
        return w;
    endfunction

endpackage

// File: rtl/flip_decode.sv
// Combinational decode of one flip pattern plus side-channel bits into a
// 6-bit data symbol, flagging flips that carry no legal code.
module flip_decode
    import rx_flip_decoder_pkg::*;
(
    input  logic [6:0] flip,
    input  logic [3:0] aux,
    output logic [5:0] data,
    output logic       err
);

    logic [2:0] weight;

    assign weight = flip_weight(flip);

    always_comb begin
        data = '0;
        err  = 1'b0;
        case (weight)
            3'd0: begin
                data = {2'b00, aux};
            end
            3'd1: begin
                for (int k = 0; k < 7; k++) begin
                    if (flip[k]) begin
                        data = {4'(k + 4), aux[1:0]};
                    end
                end
            end
            3'd2: begin
                err = 1'b1;
                if (flip != IllegalFlip) begin
                    for (int i = 0; i < int'(W2Entries); i++) begin
                        if (flip == W2Table[i]) begin
                            data = W2Base + 6'(i);
                            err  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                err = 1'b1;
            end
        endcase
        if (err) begin
            data = '0;
        end
    end

endmodule

// File: rtl/rx_flip_decoder.sv
// Receive-side flip decoder: strobed line levels are differenced against a
// reference, decoded over two pipeline stages and buffered in a 2-entry FIFO.
module rx_flip_decoder
    import rx_flip_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Rx_Lines,
    input  logic       Rx_Strobe,
    input  logic [3:0] Rx_Aux,
    output logic [5:0] Rx_Data,
    output logic       Rx_Err,
    output logic       Rx_Valid,
    input  logic       Rx_Ready,
    output logic       Rx_Overflow,
    output logic [7:0] Err_Count,
    input  logic       Err_Clear
);

    state_e     state;
    logic [6:0] line_ref;

    logic       s1_valid;
    logic [6:0] s1_flip;
    logic [3:0] s1_aux;

    logic       s2_valid;
    entry_t     s2_entry;

    logic [5:0] dec_data;
    logic       dec_err;

    entry_t     mem [FifoDepth];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [1:0] count_d;

    logic       full;
    logic       pop;
    logic       push_ok;
    logic       drop;

    // Front end: reference tracking and stage 1 capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StPrime;
            line_ref <= '0;
            s1_valid <= 1'b0;
            s1_flip  <= '0;
            s1_aux   <= '0;
        end else begin
            s1_valid <= 1'b0;
            if (Rx_Strobe) begin
                case (state)
                    StPrime: begin
                        line_ref <= Rx_Lines;
                        state    <= StRun;
                    end
                    StRun: begin
                        s1_flip  <= Rx_Lines ^ line_ref;
                        s1_aux   <= Rx_Aux;
                        s1_valid <= 1'b1;
                        line_ref <= Rx_Lines;
                    end
                    default: begin
                        state <= StPrime;
                    end
                endcase
            end
        end
    end

    flip_decode u_flip_decode (
        .flip (s1_flip),
        .aux  (s1_aux),
        .data (dec_data),
        .err  (dec_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_entry <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_entry <= '{err: dec_err, data: dec_data};
            end
        end
    end

    assign full    = (count == 2'(FifoDepth));
    assign pop     = Rx_Valid && Rx_Ready;
    // A pop frees a slot in the same cycle, so a full buffer still accepts.
    assign push_ok = s2_valid && (!full || pop);
    assign drop    = s2_valid && full && !pop;

    always_comb begin
        count_d = count;
        case ({push_ok, pop})
            2'b10:   count_d = count + 2'd1;
            2'b01:   count_d = count - 2'd1;
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= s2_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_d;
        end
    end

    // Error statistics; a clear takes priority over a same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Err_Count   <= '0;
            Rx_Overflow <= 1'b0;
        end else if (Err_Clear) begin
            Err_Count   <= '0;
            Rx_Overflow <= 1'b0;
        end else begin
            if (s2_valid && s2_entry.err && (Err_Count != 8'hFF)) begin
                Err_Count <= Err_Count + 8'd1;
            end
            if (drop) begin
                Rx_Overflow <= 1'b1;
            end
        end
    end

    assign Rx_Valid = (count != 2'd0);
    assign Rx_Data  = mem[rd_ptr].data;
    assign Rx_Err   = mem[rd_ptr].err;

endmodule

// File: doc/rx_flip_decoder.md
RX_FLIP_DECODER -- requirements
Module: rx_flip_decoder

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset. Ports: clk (input, 1, rising-edge clock) and rst_n (input, 1, asynchronous active-low reset).
REQ-002 Rx_Lines  input  7  line levels, sampled only when Rx_Strobe=1.
REQ-003 Rx_Strobe  input  1  one-cycle qualifier; one symbol per pulse.
REQ-004 Rx_Aux  input  4  side-channel bits for the data bits the flip pattern cannot carry; sampled with Rx_Strobe.
REQ-005 Rx_Data  output  6  decoded Tx_Data[15:10] at the head of the output buffer.
REQ-006 Rx_Err  output  1  head entry came from an illegal flip pattern.
REQ-007 Rx_Valid  output  1  output buffer not empty.
REQ-008 Rx_Ready  input  1  consumer accept; a pop occurs when Rx_Valid and Rx_Ready are both 1.
REQ-009 Rx_Overflow  output  1  sticky flag; a decoded symbol was dropped.
REQ-010 Err_Count  output  8  saturating count of illegal patterns.
REQ-011 Err_Clear  input  1  synchronous clear of Err_Count and Rx_Overflow.

Function
REQ-012 State machine: PRIME and RUN. In PRIME, a strobe SHALL load the line reference register, produce no output, and move the block to RUN.
REQ-013 In RUN, each strobe SHALL compute flip = Rx_Lines XOR reference, then load Rx_Lines into the reference; this happens even when the symbol is later dropped.
REQ-014 Stage 1 SHALL register {flip, Rx_Aux}. Stage 2 SHALL decode and write to the buffer. An entry strobed at edge N SHALL give Rx_Valid=1 after edge N+2 when the buffer was empty.
REQ-015 Weight-0 flip SHALL decode to Rx_Data = {2'b00, Aux[3:0]}.
REQ-016 Weight-1 flip with bit k set (k = 0..6) SHALL decode to Rx_Data[5:2] = 4+k and Rx_Data[1:0] = Aux[1:0].
REQ-017 Weight-2 flips SHALL decode to 0x2C..0x3F by this table:
03,05,09,11,21,41 -> 2C..31; 06,0A,12,22,42 -> 32..36; 0C,14,24,44 -> 37..3A; 18,28,48 -> 3B..3D; 30 -> 3E; 50 -> 3F.
REQ-018 Flip 0x60, and any flip of weight 3 or more, SHALL be illegal: write Rx_Data = 0x00 with Rx_Err = 1, and increment Err_Count.
REQ-019 Err_Count SHALL saturate at 255. If Err_Clear and an error occur in the same cycle, Err_Count SHALL become 0 (the clear wins).
REQ-020 The output buffer SHALL be a 2-entry FIFO. A push and a pop in the same cycle SHALL both be allowed at any occupancy.
REQ-021 A stage-2 write when the FIFO is full and no pop occurs SHALL drop the entry and set Rx_Overflow. The entry SHALL still count toward Err_Count if it is illegal.
REQ-022 Rx_Data and Rx_Err SHALL be held stable while Rx_Valid=1 and Rx_Ready=0.
REQ-023 A strobe during a stall SHALL still be decoded. There is no backpressure toward Rx_Strobe.

Reset
REQ-024 When rst_n=0, the module SHALL set state=PRIME, reference=0, stage valid bits=0, FIFO empty, Rx_Data=0, Rx_Err=0, Rx_Valid=0, Rx_Overflow=0, Err_Count=0.
REQ-025 Reset mid-operation SHALL discard in-flight and buffered symbols. After release, the next strobe SHALL be a PRIME strobe.

Structure
REQ-026 A shared package SHALL hold the 20-entry weight-2 table, the 0x60 illegal constant, the state enum, and FIFO depth = 2.
REQ-027 Sub-module flip_decode SHALL be purely combinational: flip and aux in, data and err out. It SHALL be instantiated once in stage 2.

Verification
REQ-028 Reset; strobe Lines=0x00 (PRIME, no output); strobe Lines=0x01, Aux=0x3 -> Rx_Valid=1 two edges later, Rx_Data=0x13, Rx_Err=0.
REQ-029 From reference 0x01, strobe Lines=0x51 (flip 0x50) -> Rx_Data=0x3F. Then strobe Lines=0x51 (flip 0x00), Aux=0xA -> Rx_Data=0x0A.
REQ-030 Flips 0x60 and then 0x07 -> two entries with Rx_Data=0x00 and Rx_Err=1, and Err_Count=2. Pulse Err_Clear -> Err_Count=0.
REQ-031 Rx_Ready=0 and three legal strobes (flips 0x03, 0x05, 0x09) -> FIFO holds 0x2C and 0x2D, Rx_Overflow=1. Raise Rx_Ready -> pops 0x2C then 0x2D.
REQ-032 Drive 300 illegal flips -> Err_Count holds 255.
REQ-033 Assert rst_n=0 with two entries buffered and one in flight -> Rx_Valid=0 immediately. After release, the first strobe produces no output.
